lm07_read_sequencer: RTL and testbench

//  SPI read master for the LM07/LM70-family temperature sensor. Drives cs_n/sck, shifts in the 16-bit

---
 rtl/lm07_read_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_lm07_read_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lm07_read_sequencer.sv
// SPI read master for LM07/LM70-family temperature sensors: on-demand or periodic 16-bit reads.
// Optional threshold alarm with hysteresis when LM07_ALARM_EN is defined.
module lm07_read_sequencer #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned NBITS       = 16,
    parameter int unsigned CS_HOLD     = 4,
    parameter int unsigned POLL_PERIOD = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              auto_en,
    input  logic              sio,
`ifdef LM07_ALARM_EN
    input  logic signed [8:0] thr_hi,
    input  logic signed [8:0] thr_lo,
    output logic              alarm,
`endif
    output logic              cs_n,
    output logic              sck,
    output logic              busy,
    output logic [15:0]       temp_raw,
    output logic [8:0]        temp_deg,
    output logic              temp_valid
);

    localparam int unsigned CntMax = (CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned BitW   = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned PollW  = $clog2(POLL_PERIOD);

    localparam logic [CntW-1:0]  DivLast  = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0]  HoldLast = CntW'(CS_HOLD - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(NBITS - 1);
    localparam logic [PollW-1:0] PollLast = PollW'(POLL_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [BitW-1:0]  bit_q, bit_d;
    logic             sck_q, sck_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic [15:0]      shift_q, shift_d;
    logic [15:0]      raw_q, raw_d;
    logic             valid_q, valid_d;
    logic             pending_q, pending_d;
    logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
    logic             poll_hit_q, poll_hit_d;
    logic             req, accept;
`ifdef LM07_ALARM_EN
    logic             alarm_q, alarm_d;
    logic signed [8:0] deg_new;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sck_d      = sck_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        shift_d    = shift_q;
        raw_d      = raw_q;
        valid_d    = 1'b0;
        req        = start | poll_hit_q | pending_q;
        accept     = 1'b0;

        case (state_q)
            StIdle: begin
                if (ena && req) begin
                    accept  = 1'b1;
                    state_d = StSetup;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
                    shift_d = '0;
                end
            end
            StSetup: begin
                if (cnt_q == DivLast) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StShift: begin
                if (cnt_q == DivLast) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        // Sample on the rising sck edge; sensor changed sio on the previous fall.
                        sck_d   = 1'b1;
                        shift_d = {shift_q[14:0], sio};
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == BitLast) begin
                            cs_n_d  = 1'b1;
                            raw_d   = shift_q;
                            valid_d = 1'b1;
                            state_d = StHold;
                        end else begin
                            bit_d = bit_q + BitW'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Any request not taken this cycle (busy or disabled) is remembered, one deep.
        pending_d = accept ? 1'b0 : (pending_q | start | poll_hit_q);

        poll_hit_d = auto_en & ~busy_q & (poll_cnt_q == PollLast);
        if (!auto_en || valid_d) begin
            poll_cnt_d = '0;
        end else if (!busy_q) begin
            poll_cnt_d = (poll_cnt_q == PollLast) ? '0 : poll_cnt_q + PollW'(1);
        end else begin
            poll_cnt_d = poll_cnt_q;
        end
    end

`ifdef LM07_ALARM_EN
    always_comb begin
        deg_new = $signed(shift_q[15:7]);
        alarm_d = alarm_q;
        if (valid_d) begin
            if (deg_new >= thr_hi) begin
                alarm_d = 1'b1;
            end else if (deg_new < thr_lo) begin
                alarm_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            shift_q    <= '0;
            raw_q      <= '0;
            valid_q    <= 1'b0;
            pending_q  <= 1'b0;
            poll_cnt_q <= '0;
            poll_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            shift_q    <= shift_d;
            raw_q      <= raw_d;
            valid_q    <= valid_d;
            pending_q  <= pending_d;
            poll_cnt_q <= poll_cnt_d;
            poll_hit_q <= poll_hit_d;
        end
    end

    assign cs_n       = cs_n_q;
    assign sck        = sck_q;
    assign busy       = busy_q;
    assign temp_raw   = raw_q;
    assign temp_deg   = raw_q[15:7];
    assign temp_valid = valid_q;

endmodule

// File: tb/tb_lm07_read_sequencer.sv
// Bench for lm07_read_sequencer: behavioural LM07 sensor model plus a scoreboard of expected reads.
module tb_lm07_read_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ena = 1'b0;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic        sio;
    logic        cs_n, sck, busy, temp_valid;
    logic [15:0] temp_raw;
    logic [8:0]  temp_deg;
`ifdef LM07_ALARM_EN
    logic signed [8:0] thr_hi = 9'sd45;
    logic signed [8:0] thr_lo = 9'sd40;
    logic              alarm;
`endif

    lm07_read_sequencer #(
        .CLK_DIV    (2),
        .NBITS      (16),
        .CS_HOLD    (4),
        .POLL_PERIOD(64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .auto_en   (auto_en),
        .sio       (sio),
`ifdef LM07_ALARM_EN
        .thr_hi    (thr_hi),
        .thr_lo    (thr_lo),
        .alarm     (alarm),
`endif
        .cs_n      (cs_n),
        .sck       (sck),
        .busy      (busy),
        .temp_raw  (temp_raw),
        .temp_deg  (temp_deg),
        .temp_valid(temp_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sensor model: MSB presented when cs_n changes, shifts on the falling edge of ~cs_n & sck.
    logic [15:0] model_word = 16'h0000;
    logic [15:0] model_sh = 16'h0000;
    wire         sgate = ~cs_n & sck;
    assign sio = model_sh[15];
    always @(cs_n) model_sh <= model_word;
    always @(negedge sgate) model_sh <= {model_sh[14:0], 1'b0};

    typedef struct {
        logic [15:0] raw;
        logic [8:0]  deg;
        int          vcyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [15:0] word;
        logic [15:0] raw;
        logic [8:0]  deg;
    } vec_t;
    vec_t vecs[8];

    int n_vec = 0;
    int n_err = 0;
    int sck_rises = 0;
    logic prev_cs = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic push_exp(input logic [15:0] raw, input logic [8:0] deg, input int vcyc);
        exp_t e;
        e.raw  = raw;
        e.deg  = deg;
        e.vcyc = vcyc;
        sb.push_back(e);
    endtask

    // Start is driven after edge k and sampled at k+1, so valid appears after edge k+67.
    task automatic issue_start(input logic [15:0] word, input logic [15:0] raw,
                               input logic [8:0] deg);
        model_word = word;
        start = 1'b1;
        push_exp(raw, deg, cyc + 67);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit need_idle);
        int n = 0;
        while ((sb.size() != 0 || (need_idle && busy)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            flag("wait_timeout");
            sb.delete();
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial forever begin
        @(posedge sck);
        sck_rises++;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (cs_n && sck) flag("sck_high_with_cs_high");
            if (cs_n !== prev_cs && sck) flag("cs_change_while_sck_high");
        end
        if (prev_cs && !cs_n) sck_rises = 0;
        prev_cs = cs_n;
        if (temp_valid) begin
            if (sb.size() == 0) begin
                flag("unexpected_temp_valid");
            end else begin
                e = sb.pop_front();
                chk("valid_cycle", cyc, e.vcyc);
                chk("temp_raw", {16'h0, temp_raw}, {16'h0, e.raw});
                chk("temp_deg", {23'h0, temp_deg}, {23'h0, e.deg});
                chk("sck_rises", sck_rises, 16);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        int k;
        vecs[0] = '{16'h191F, 16'h191F, 9'h032};
        vecs[1] = '{16'hE49F, 16'hE49F, 9'h1C9};
        vecs[2] = '{16'h0000, 16'h0000, 9'h000};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 9'h1FF};
        vecs[4] = '{16'h8000, 16'h8000, 9'h100};
        vecs[5] = '{16'h7FFF, 16'h7FFF, 9'h0FF};
        vecs[6] = '{16'h0080, 16'h0080, 9'h001};
        vecs[7] = '{16'hA5C3, 16'hA5C3, 9'h14B};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {31'h0, cs_n}, 32'h1);
        chk("rst_sck", {31'h0, sck}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_temp_raw", {16'h0, temp_raw}, 32'h0);
        chk("rst_temp_deg", {23'h0, temp_deg}, 32'h0);
        chk("rst_temp_valid", {31'h0, temp_valid}, 32'h0);
        rst_n = 1'b1;
        ena = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            issue_start(vecs[i].word, vecs[i].raw, vecs[i].deg);
            chk("busy_after_start", {31'h0, busy}, 32'h1);
            chk("cs_low_after_start", {31'h0, cs_n}, 32'h0);
            wait_done(300, 1'b1);
            @(negedge clk);
        end

        // Requests during busy collapse into exactly one extra read after HOLD.
        k = cyc;
        issue_start(16'h191F, 16'h191F, 9'h032);
        push_exp(16'h191F, 9'h032, k + 138);
        wait_until(k + 20);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(k + 40);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(k + 69);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(k + 71);
        chk("hold_cs_high", {31'h0, cs_n}, 32'h1);
        @(negedge clk);
        chk("second_cs_low", {31'h0, cs_n}, 32'h0);
        wait_done(300, 1'b1);
        repeat (200) @(negedge clk);
        chk("no_third_read", {31'h0, busy}, 32'h0);

        // ena low keeps the request pending rather than dropping it.
        ena = 1'b0;
        model_word = 16'h8000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("ena_low_blocks_busy", {31'h0, busy}, 32'h0);
        chk("ena_low_blocks_cs", {31'h0, cs_n}, 32'h1);
        ena = 1'b1;
        push_exp(16'h8000, 9'h100, cyc + 67);
        wait_done(300, 1'b1);

        // Periodic reads: first at +131 from enable, then every 135 cycles.
        repeat (5) @(negedge clk);
        model_word = 16'h1500;
        k = cyc;
        auto_en = 1'b1;
        push_exp(16'h1500, 9'h02A, k + 131);
        push_exp(16'h1500, 9'h02A, k + 266);
        push_exp(16'h1500, 9'h02A, k + 401);
        wait_done(700, 1'b0);
        auto_en = 1'b0;
        repeat (300) @(negedge clk);
        chk("auto_off_idle", {31'h0, busy}, 32'h0);

        // Reset during bit 7 (sck high) aborts the read and clears the word.
        model_word = 16'hE49F;
        k = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(k + 34);
        chk("bit7_sck_high", {31'h0, sck}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", {31'h0, cs_n}, 32'h1);
        chk("midrst_sck", {31'h0, sck}, 32'h0);
        chk("midrst_temp_raw", {16'h0, temp_raw}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue_start(16'hE49F, 16'hE49F, 9'h1C9);
        wait_done(300, 1'b1);

`ifdef LM07_ALARM_EN
        issue_start(16'h191F, 16'h191F, 9'h032);
        wait_done(300, 1'b1);
        chk("alarm_50C", {31'h0, alarm}, 32'h1);
        issue_start(16'h1500, 16'h1500, 9'h02A);
        wait_done(300, 1'b1);
        chk("alarm_42C_hold", {31'h0, alarm}, 32'h1);
        issue_start(16'h1300, 16'h1300, 9'h026);
        wait_done(300, 1'b1);
        chk("alarm_38C_clear", {31'h0, alarm}, 32'h0);
`endif

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
